// File: rtl/fp_post_normalize.sv
// rtl/fp_post_normalize.sv - FP add/sub back end: post-complement, iterative normalise, RNE round, pack
module fp_post_normalize #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic                      in_complement,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [MANT_W+4:0]         in_sum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W:0]     out_result,
    output logic                      out_zero,
    output logic                      out_overflow
);
    localparam int M_W = MANT_W + 4;   // hidden + frac + G/R/S

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FIXUP = 3'd1;
    localparam logic [2:0] S_NORM  = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic             sign_q;
    logic             comp_q;
    logic             carry_q;         // after FIXUP: pending right-shift request
    logic             zero_q;
    logic [EXP_W:0]   exp_q;           // one spare bit so overflow is visible
    logic [M_W-1:0]   m_q;

    logic [M_W-1:0]   m_fix;
    logic             fix_zero;
    logic [MANT_W:0]  mant;
    logic             round_up;
    logic [MANT_W+1:0] rnd_sum;
    logic [EXP_W:0]   rnd_exp;
    logic [MANT_W-1:0] rnd_frac;
    logic             rnd_hidden;
    logic             rnd_ovf;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Post-complement of the captured magnitude and detection of an exact zero result
    always_comb begin
        m_fix    = m_q;
        if (comp_q && !carry_q) begin
            m_fix = ~m_q + M_W'(1);
        end
        fix_zero = (m_fix == '0) && !(!comp_q && carry_q);
    end

    // Round-to-nearest-even on the normalised mantissa and overflow detection
    always_comb begin
        mant       = m_q[M_W-1:3];
        round_up   = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
        rnd_sum    = {1'b0, mant} + (MANT_W+2)'(round_up);
        rnd_exp    = exp_q + (EXP_W+1)'(rnd_sum[MANT_W+1]);
        rnd_frac   = rnd_sum[MANT_W+1] ? '0 : rnd_sum[MANT_W-1:0];
        rnd_hidden = rnd_sum[MANT_W+1] | rnd_sum[MANT_W];
        rnd_ovf    = rnd_exp[EXP_W] | (&rnd_exp[EXP_W-1:0]);
    end

    // Operation sequencer: capture, fix up, normalise one bit per cycle, round/pack, hand off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            sign_q       <= 1'b0;
            comp_q       <= 1'b0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            exp_q        <= '0;
            m_q          <= '0;
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q  <= in_sign;
                        comp_q  <= in_complement;
                        carry_q <= in_sum[MANT_W+4];
                        zero_q  <= 1'b0;
                        exp_q   <= {1'b0, in_exp};
                        m_q     <= in_sum[MANT_W+3:0];
                        state   <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    m_q <= m_fix;
                    // Under subtraction the carry only marks a positive difference; drop it
                    if (comp_q) begin
                        carry_q <= 1'b0;
                    end
                    if (comp_q && !carry_q) begin
                        sign_q <= ~sign_q;
                    end
                    if (fix_zero) begin
                        zero_q <= 1'b1;
                        sign_q <= comp_q ? 1'b0 : sign_q;
                        state  <= S_ROUND;
                    end else begin
                        state  <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (carry_q) begin
                        // Right shift lands the carry in the hidden bit; the next NORM
                        // cycle then sees hidden=1, so this step counts as one shift.
                        m_q     <= {1'b1, m_q[M_W-1:2], m_q[1] | m_q[0]};
                        exp_q   <= exp_q + 1'b1;
                        carry_q <= 1'b0;
                    end else if (m_q[M_W-1] || exp_q <= 1) begin
                        state <= S_ROUND;
                    end else begin
                        m_q   <= {m_q[M_W-2:0], 1'b0};
                        exp_q <= exp_q - 1'b1;
                    end
                end
                S_ROUND: begin
                    out_zero     <= zero_q;
                    out_overflow <= 1'b0;
                    if (zero_q) begin
                        out_result <= {sign_q, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
                    end else if (rnd_ovf) begin
                        out_result   <= {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                        out_overflow <= 1'b1;
                    end else if (!rnd_hidden) begin
                        out_result <= {sign_q, {EXP_W{1'b0}}, rnd_frac};
                    end else begin
                        out_result <= {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
